id_ex_stage: RTL and testbench

- ID/EX pipeline register for the five-stage MIPS core.
- Captures the decoder's control bundle, the register operands and the immediate at the ID/EX boundary.
- Resolves the EX destination register number.
- Detects load-use hazards, inserting one bubble and stalling PC and IF/ID.
- Honours a branch/jump flush from downstream.
- Feeds the EX stage and the MEM→EX forwarding logic.

---
 rtl/id_ex_stage.sv | 148 ++++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the five-stage MIPS core.
// Resolves the EX destination register, detects load-use hazards and counts stall cycles.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_reg_write,
  input  logic          id_mem_write,
  input  logic [1:0]    id_s_data_write,
  input  logic [1:0]    id_s_num_write,
  input  logic          id_s_b,
  input  logic          id_ext,
  input  logic [3:0]    id_aluop,
  input  logic [1:0]    id_s_npc,
  input  logic [DW-1:0] id_pc,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic [4:0]    id_rd,
  input  logic          flush,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_write,
  output logic          ex_s_b,
  output logic          ex_ext,
  output logic [1:0]    ex_s_data_write,
  output logic [1:0]    ex_s_num_write,
  output logic [1:0]    ex_s_npc,
  output logic [3:0]    ex_aluop,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_wreg,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_write;
    logic          s_b;
    logic          ext;
    logic [1:0]    s_data_write;
    logic [1:0]    s_num_write;
    logic [1:0]    s_npc;
    logic [3:0]    aluop;
    logic [DW-1:0] pc;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    wreg;
  } ex_bundle_t;

  ex_bundle_t    ex_q, ex_d, bubble;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          uses_rs, uses_rt, ex_load;
  logic [4:0]    dest;
  logic          reg_write_s, mem_write_s;

  // Hazard check looks only at the registered EX bundle and the live ID fields.
  always_comb begin
    uses_rs = id_valid & (id_s_npc != 2'b10) & (id_aluop != 4'b1010);
    uses_rt = id_valid & (~id_s_b | id_mem_write) & (id_s_npc != 2'b10);
    ex_load = ex_q.valid & ex_q.reg_write & (ex_q.s_data_write == 2'b10);
    stall   = ex_load & (ex_q.wreg != 5'd0) &
              ((uses_rs & (id_rs == ex_q.wreg)) | (uses_rt & (id_rt == ex_q.wreg)));
  end

  always_comb begin
    unique case (id_s_num_write)
      2'b00:   dest = id_rt;
      2'b01:   dest = id_rd;
      2'b10:   dest = 5'd31;
      default: dest = 5'd0;
    endcase
    // jr never writes a register; jr/j/jal never store.
    reg_write_s = id_reg_write & (id_s_npc != 2'b01);
    mem_write_s = id_mem_write & (id_s_npc != 2'b01) & (id_s_npc != 2'b10);
  end

  always_comb begin
    bubble       = '0;
    bubble.s_npc = 2'b11;
    ex_d         = bubble;
    if (!flush && !stall && id_valid) begin
      ex_d.valid        = 1'b1;
      ex_d.reg_write    = reg_write_s;
      ex_d.mem_write    = mem_write_s;
      ex_d.s_b          = id_s_b;
      ex_d.ext          = id_ext;
      ex_d.s_data_write = id_s_data_write;
      ex_d.s_num_write  = id_s_num_write;
      ex_d.s_npc        = id_s_npc;
      ex_d.aluop        = id_aluop;
      ex_d.pc           = id_pc;
      ex_d.rs_data      = id_rs_data;
      ex_d.rt_data      = id_rt_data;
      ex_d.imm          = id_imm;
      ex_d.rs           = id_rs;
      ex_d.rt           = id_rt;
      ex_d.wreg         = reg_write_s ? dest : 5'd0;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= bubble;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid        = ex_q.valid;
  assign ex_reg_write    = ex_q.reg_write;
  assign ex_mem_write    = ex_q.mem_write;
  assign ex_s_b          = ex_q.s_b;
  assign ex_ext          = ex_q.ext;
  assign ex_s_data_write = ex_q.s_data_write;
  assign ex_s_num_write  = ex_q.s_num_write;
  assign ex_s_npc        = ex_q.s_npc;
  assign ex_aluop        = ex_q.aluop;
  assign ex_pc           = ex_q.pc;
  assign ex_rs_data      = ex_q.rs_data;
  assign ex_rt_data      = ex_q.rt_data;
  assign ex_imm          = ex_q.imm;
  assign ex_rs           = ex_q.rs;
  assign ex_rt           = ex_q.rt;
  assign ex_wreg         = ex_q.wreg;
  assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, saturation run and a
// randomized run against a behavioural model. Counter width is reduced so saturation is quick.
module tb_id_ex_stage;
  localparam int DW    = 32;
  localparam int TB_CW = 8;

  logic clk, rst;
  logic id_valid, id_reg_write, id_mem_write, id_s_b, id_ext, flush;
  logic [1:0] id_s_data_write, id_s_num_write, id_s_npc;
  logic [3:0] id_aluop;
  logic [DW-1:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs, id_rt, id_rd;
  logic ex_valid, ex_reg_write, ex_mem_write, ex_s_b, ex_ext, stall;
  logic [1:0] ex_s_data_write, ex_s_num_write, ex_s_npc;
  logic [3:0] ex_aluop;
  logic [DW-1:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_wreg;
  logic [TB_CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DW(DW), .CW(TB_CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_reg_write(id_reg_write),
    .id_mem_write(id_mem_write), .id_s_data_write(id_s_data_write),
    .id_s_num_write(id_s_num_write), .id_s_b(id_s_b), .id_ext(id_ext),
    .id_aluop(id_aluop), .id_s_npc(id_s_npc), .id_pc(id_pc),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_s_b(ex_s_b), .ex_ext(ex_ext), .ex_s_data_write(ex_s_data_write),
    .ex_s_num_write(ex_s_num_write), .ex_s_npc(ex_s_npc), .ex_aluop(ex_aluop),
    .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .stall(stall), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, rw, mw, input logic [1:0] sdw, snw, input logic sb,
                       input logic [3:0] op, input logic [1:0] npc,
                       input logic [4:0] rs, rt, rd, input logic fl);
    id_valid = v; id_reg_write = rw; id_mem_write = mw; id_s_data_write = sdw;
    id_s_num_write = snw; id_s_b = sb; id_aluop = op; id_s_npc = npc;
    id_rs = rs; id_rt = rt; id_rd = rd; flush = fl;
  endtask

  typedef struct {
    logic v, rw, mw, sb, fl;
    logic [1:0] sdw, snw, npc;
    logic [3:0] op;
    logic [4:0] rs, rt, rd;
    logic e_stall, e_v, e_rw, e_mw;
    logic [4:0] e_wreg;
    logic [1:0] e_npc, e_sdw;
    int e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, rw, mw, input logic [1:0] sdw, snw,
                              input logic sb, input logic [1:0] npc,
                              input logic [4:0] rs, rt, rd, input logic fl,
                              input logic es, ev, erw, emw, input logic [4:0] ew,
                              input logic [1:0] enpc, esdw, input int ecnt);
    vec_t t;
    t.v = v; t.rw = rw; t.mw = mw; t.sdw = sdw; t.snw = snw; t.sb = sb; t.op = 4'h0;
    t.npc = npc; t.rs = rs; t.rt = rt; t.rd = rd; t.fl = fl;
    t.e_stall = es; t.e_v = ev; t.e_rw = erw; t.e_mw = emw; t.e_wreg = ew;
    t.e_npc = enpc; t.e_sdw = esdw; t.e_cnt = ecnt;
    return t;
  endfunction

  // Reference bundle: {valid,rw,mw,s_b,ext,sdw,snw,npc,aluop,pc,rs_data,rt_data,imm,rs,rt,wreg}
  typedef struct packed {
    logic v, rw, mw, sb, ext;
    logic [1:0] sdw, snw, npc;
    logic [3:0] op;
    logic [DW-1:0] pc, rsd, rtd, imm;
    logic [4:0] rs, rt, wreg;
  } bundle_t;

  function automatic bundle_t actual();
    return {ex_valid, ex_reg_write, ex_mem_write, ex_s_b, ex_ext, ex_s_data_write,
            ex_s_num_write, ex_s_npc, ex_aluop, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
            ex_rs, ex_rt, ex_wreg};
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9; regs[3] = 5'd31;
    return regs[$urandom_range(0, 3)];
  endfunction

  vec_t vecs [16];
  bundle_t m, bubble_m;
  int m_cnt;
  logic m_stall, m_load, reads_rs, reads_rt, is_bubble;
  logic [4:0] dst;

  initial begin
    id_ext = 1'b0; id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;

    // Reset held two cycles with addu $8 <- $16 + $17 presented.
    rst = 1'b1;
    drive(1, 1, 0, 2'b01, 2'b01, 0, 4'h0, 2'b11, 5'd16, 5'd17, 5'd8, 0);
    tick(); tick();
    chk("reset ex_valid", ex_valid, 1'b0);
    chk("reset ex_reg_write", ex_reg_write, 1'b0);
    chk("reset ex_s_npc", ex_s_npc, 2'b11);
    chk("reset stall_cnt", stall_cnt, 0);
    chk("reset ex_wreg", ex_wreg, 0);
    rst = 1'b0;
    tick();
    chk("post-reset addu capture", {ex_valid, ex_aluop, ex_wreg}, {1'b1, 4'h0, 5'd8});

    //          v rw mw sdw    snw    sb npc    rs  rt  rd fl  st v rw mw wreg npc    sdw    cnt
    vecs[0]  = mk(1,1,0,2'b10,2'b00,1,2'b11,16, 8, 0, 0, 0,1,1,0,  8,2'b11,2'b10,0); // lw $8
    vecs[1]  = mk(1,1,0,2'b01,2'b01,0,2'b11, 8,10, 9, 0, 1,0,0,0,  0,2'b11,2'b00,1); // addu uses $8
    vecs[2]  = mk(1,1,0,2'b01,2'b01,0,2'b11, 8,10, 9, 0, 0,1,1,0,  9,2'b11,2'b01,1); // re-presented
    vecs[3]  = mk(1,1,0,2'b10,2'b00,1,2'b11,16, 8, 0, 0, 0,1,1,0,  8,2'b11,2'b10,1); // lw $8
    vecs[4]  = mk(1,1,0,2'b01,2'b00,1,2'b11, 9, 8, 0, 0, 0,1,1,0,  8,2'b11,2'b01,1); // addi $8,$9
    vecs[5]  = mk(1,1,0,2'b10,2'b00,1,2'b11,16, 8, 0, 0, 0,1,1,0,  8,2'b11,2'b10,1); // lw $8
    vecs[6]  = mk(1,0,1,2'b00,2'b00,1,2'b11,16, 8, 0, 0, 1,0,0,0,  0,2'b11,2'b00,2); // sw $8
    vecs[7]  = mk(1,0,1,2'b00,2'b00,1,2'b11,16, 8, 0, 0, 0,1,0,1,  0,2'b11,2'b00,2); // sw again
    vecs[8]  = mk(1,1,0,2'b10,2'b00,1,2'b11,16, 0, 0, 0, 0,1,1,0,  0,2'b11,2'b10,2); // lw $0
    vecs[9]  = mk(1,1,0,2'b01,2'b01,0,2'b11, 0, 0, 9, 0, 0,1,1,0,  9,2'b11,2'b01,2); // addu $0
    vecs[10] = mk(1,1,0,2'b10,2'b00,1,2'b11,16, 8, 0, 0, 0,1,1,0,  8,2'b11,2'b10,2); // lw $8
    vecs[11] = mk(1,1,0,2'b01,2'b01,0,2'b11, 8,10, 9, 1, 1,0,0,0,  0,2'b11,2'b00,2); // stall+flush
    vecs[12] = mk(1,1,1,2'b01,2'b01,0,2'b01,31, 0, 5, 0, 0,1,0,0,  0,2'b01,2'b01,2); // jr $31
    vecs[13] = mk(1,1,0,2'b00,2'b10,0,2'b10, 0, 0, 0, 0, 0,1,1,0, 31,2'b10,2'b00,2); // jal
    vecs[14] = mk(0,1,1,2'b01,2'b01,0,2'b11, 8, 8, 8, 0, 0,0,0,0,  0,2'b11,2'b00,2); // id_valid=0
    vecs[15] = mk(1,1,0,2'b01,2'b01,0,2'b11, 1, 2, 3, 1, 0,0,0,0,  0,2'b11,2'b00,2); // flush

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].v, vecs[i].rw, vecs[i].mw, vecs[i].sdw, vecs[i].snw, vecs[i].sb,
            vecs[i].op, vecs[i].npc, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].fl);
      id_pc = 32'h100 + 32'(i * 4);
      id_imm = 32'hA000 + 32'(i);
      #2;
      chk($sformatf("vec%0d stall", i), stall, vecs[i].e_stall);
      tick();
      chk($sformatf("vec%0d ctrl", i),
          {ex_valid, ex_reg_write, ex_mem_write, ex_wreg, ex_s_npc, ex_s_data_write},
          {vecs[i].e_v, vecs[i].e_rw, vecs[i].e_mw, vecs[i].e_wreg, vecs[i].e_npc, vecs[i].e_sdw});
      chk($sformatf("vec%0d data", i), {ex_pc, ex_imm},
          vecs[i].e_v ? {id_pc, id_imm} : 64'd0);
      chk($sformatf("vec%0d stall_cnt", i), stall_cnt, vecs[i].e_cnt);
    end

    // Saturation: lw $8 / addu using $8 pairs give one stall per two cycles.
    for (int k = 0; k < (1 << TB_CW) + 2; k++) begin
      drive(1, 1, 0, 2'b10, 2'b00, 1, 4'h0, 2'b11, 16, 8, 0, 0);
      tick();
      drive(1, 1, 0, 2'b01, 2'b01, 0, 4'h0, 2'b11, 8, 10, 9, 0);
      #2;
      if (k == 0) chk("sat pair stall", stall, 1'b1);
      tick();
      if (k == 0) chk("sat first increment", stall_cnt, 3);
    end
    chk("stall_cnt saturated", stall_cnt, {TB_CW{1'b1}});

    // Randomized run against the behavioural model.
    bubble_m = '0;
    bubble_m.npc = 2'b11;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m = bubble_m;
    m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 2'($urandom),
            2'($urandom), 1'($urandom), 4'($urandom), 2'($urandom),
            pick_reg(), pick_reg(), pick_reg(), $urandom_range(0, 7) == 0);
      id_ext = 1'($urandom);
      id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;

      // Hazard: EX holds a real load into a nonzero register the ID instruction reads.
      m_load = m.v && m.rw && (m.sdw == 2'b10);
      reads_rs = id_valid && (id_s_npc != 2'b10) && (id_aluop != 4'b1010);
      reads_rt = id_valid && (!id_s_b || id_mem_write) && (id_s_npc != 2'b10);
      m_stall = m_load && (m.wreg != 0) &&
                ((reads_rs && id_rs == m.wreg) || (reads_rt && id_rt == m.wreg));
      #2;
      chk($sformatf("rand%0d stall", n), stall, m_stall);

      if (rst) begin
        m = bubble_m;
        m_cnt = 0;
      end else begin
        if (m_stall && !flush) m_cnt = (m_cnt == (1 << TB_CW) - 1) ? m_cnt : m_cnt + 1;
        is_bubble = flush || m_stall || !id_valid;
        if (is_bubble) begin
          m = bubble_m;
        end else begin
          case (id_s_num_write)
            2'b00: dst = id_rt;
            2'b01: dst = id_rd;
            2'b10: dst = 5'd31;
            default: dst = 5'd0;
          endcase
          m.v = 1'b1;
          m.rw = id_reg_write && (id_s_npc != 2'b01);
          m.mw = id_mem_write && !(id_s_npc == 2'b01 || id_s_npc == 2'b10);
          m.sb = id_s_b; m.ext = id_ext; m.sdw = id_s_data_write; m.snw = id_s_num_write;
          m.npc = id_s_npc; m.op = id_aluop; m.pc = id_pc; m.rsd = id_rs_data;
          m.rtd = id_rt_data; m.imm = id_imm; m.rs = id_rs; m.rt = id_rt;
          m.wreg = m.rw ? dst : 5'd0;
        end
      end
      tick();
      chk($sformatf("rand%0d ex", n), actual(), m);
      chk($sformatf("rand%0d cnt", n), stall_cnt, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
